// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Standard VGA mode timing constants, raster-total helpers and
//               a minimum counter-width function shared by the timing
//               generator and the pixel divider.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package vga_timing_pkg;

    // One complete video mode: per-axis region sizes plus sync polarities
    // (polarity 0 = active-low, 1 = active-high).
    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        int hs_pol;
        int vs_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        hs_pol:   0,   vs_pol: 0
    };

    localparam vga_mode_t MODE_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hs_pol:   1,   vs_pol: 1
    };

    localparam vga_mode_t MODE_1024X768_60 = '{
        h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
        hs_pol:   0,    vs_pol: 0
    };

    // Total length of one axis: active + front porch + sync + back porch.
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input vga_mode_t m);
        return axis_total(m.h_active, m.h_fp, m.h_sync, m.h_bp);
    endfunction

    function automatic int v_total(input vga_mode_t m);
        return axis_total(m.v_active, m.v_fp, m.v_sync, m.v_bp);
    endfunction

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int min_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_div.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_div
// Description : Divides CLK down to a one-cycle pixel strobe. The phase
//               counter restarts from zero whenever the enable is low, so the
//               first strobe after enable rises comes CLK_DIV-1 cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_en,
    output logic o_p_tick
);

    localparam int                 C_DIV_W    = min_width(CLK_DIV);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);

    logic [C_DIV_W-1:0] r_div;

    // Phase counter: 0..CLK_DIV-1 while enabled, parked at 0 while disabled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div <= '0;
        end else if (!i_en || (r_div == C_DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + C_DIV_W'(1);
        end
    end

    // Reset gates the strobe so it is low for the whole reset period,
    // including the CLK_DIV=1 case where the phase compare is always true.
    assign o_p_tick = i_en && RESET_N && (r_div == C_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. Produces the pixel
//               strobe, x/y counters, polarity-configurable sync pulses,
//               active-video flag and line/frame start strobes, all
//               registered so they change on the same CLK edge.
//               Optional build macro VGA_LINE_IRQ_EN adds the line-match
//               pulse line_irq; without it line_irq is tied low.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = MODE_640X480_60.h_active,
    parameter int H_FP     = MODE_640X480_60.h_fp,
    parameter int H_SYNC   = MODE_640X480_60.h_sync,
    parameter int H_BP     = MODE_640X480_60.h_bp,
    parameter int V_ACTIVE = MODE_640X480_60.v_active,
    parameter int V_FP     = MODE_640X480_60.v_fp,
    parameter int V_SYNC   = MODE_640X480_60.v_sync,
    parameter int V_BP     = MODE_640X480_60.v_bp,
    parameter int CLK_DIV  = 2,
    parameter int HS_POL   = MODE_640X480_60.hs_pol,
    parameter int VS_POL   = MODE_640X480_60.vs_pol,
    parameter int CNT_W    = 10
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic [CNT_W-1:0] line_cmp,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             line_irq
);

    localparam int C_H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int C_V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Sync windows as [begin, end) on each axis.
    localparam int C_HS_BEG  = H_ACTIVE + H_FP;
    localparam int C_HS_END  = C_HS_BEG + H_SYNC;
    localparam int C_VS_BEG  = V_ACTIVE + V_FP;
    localparam int C_VS_END  = C_VS_BEG + V_SYNC;

    localparam logic C_HS_ACT = (HS_POL != 0);
    localparam logic C_VS_ACT = (VS_POL != 0);

    localparam logic [CNT_W-1:0] C_X_LAST = CNT_W'(C_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_Y_LAST = CNT_W'(C_V_TOTAL - 1);

    // Reject configurations the counters cannot represent.
    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
        if ((CNT_W < min_width(C_H_TOTAL)) || (CNT_W < min_width(C_V_TOTAL))) begin : g_bad_cnt_w
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic             w_tick;
    logic             w_x_wrap;
    logic [CNT_W-1:0] w_x_nxt;
    logic [CNT_W-1:0] w_y_nxt;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_video_nxt;

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_line_start;
    logic             r_frame_start;

    vga_pixel_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_div (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .i_en     (EN),
        .o_p_tick (w_tick)
    );

    // Next raster position and the region decodes taken from it, so the
    // registered levels land on the same edge as the counters.
    always_comb begin
        w_x_wrap = (r_x == C_X_LAST);
        w_x_nxt  = w_x_wrap ? '0 : (r_x + CNT_W'(1));
        w_y_nxt  = r_y;
        if (w_x_wrap) begin
            w_y_nxt = (r_y == C_Y_LAST) ? '0 : (r_y + CNT_W'(1));
        end
        w_hs_act    = (int'(w_x_nxt) >= C_HS_BEG) && (int'(w_x_nxt) < C_HS_END);
        w_vs_act    = (int'(w_y_nxt) >= C_VS_BEG) && (int'(w_y_nxt) < C_VS_END);
        w_video_nxt = (int'(w_x_nxt) < H_ACTIVE) && (int'(w_y_nxt) < V_ACTIVE);
    end

    // Raster state: counters and levels advance on the pixel strobe, start
    // strobes live for exactly the one cycle following the loading edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_x           <= C_X_LAST;
            r_y           <= C_Y_LAST;
            r_hsync       <= ~C_HS_ACT;
            r_vsync       <= ~C_VS_ACT;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_x           <= w_x_nxt;
                r_y           <= w_y_nxt;
                r_hsync       <= w_hs_act ? C_HS_ACT : ~C_HS_ACT;
                r_vsync       <= w_vs_act ? C_VS_ACT : ~C_VS_ACT;
                r_video_on    <= w_video_nxt;
                r_line_start  <= (w_x_nxt == '0);
                r_frame_start <= (w_x_nxt == '0) && (w_y_nxt == '0);
            end
        end
    end

`ifdef VGA_LINE_IRQ_EN
    logic r_line_irq;

    // Line-match pulse alongside line_start; y never reaches V_TOTAL, so an
    // out-of-range compare value simply never matches.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_line_irq <= 1'b0;
        end else begin
            r_line_irq <= w_tick && (w_x_nxt == '0) && (w_y_nxt == line_cmp);
        end
    end

    assign line_irq = r_line_irq;
`else
    logic w_unused_line_cmp;

    assign w_unused_line_cmp = ^line_cmp;
    assign line_irq          = 1'b0;
`endif

    assign p_tick      = w_tick;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA synchroniser. It generates pixel-clock strobe, h/v counters, sync pulses with configurable polarity, and an active-video flag for any standard mode. It also generates line/frame start strobes, and all outputs are aligned to the same CLK edge. It sits between the board clock and the pixel generator / frame-buffer reader.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, CLK cycles per pixel (>=1)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CNT_W, 10, counter width; elaboration error if 2^CNT_W < H_TOTAL or V_TOTAL

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous, active-low reset
EN  in  1  timing enable; low freezes the raster
line_cmp  in  CNT_W  line-match compare value (optional feature)
p_tick  out  1  pixel strobe, one CLK wide
pixel_x  out  CNT_W  horizontal counter, 0..H_TOTAL-1
pixel_y  out  CNT_W  vertical counter, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per HS_POL
vsync  out  1  vertical sync, polarity per VS_POL
video_on  out  1  high when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
line_start  out  1  one-CLK pulse when pixel_x becomes 0
frame_start  out  1  one-CLK pulse when (pixel_x,pixel_y) becomes (0,0)
line_irq  out  1  line-match pulse (optional feature)

Behaviour:
- Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Region order on each axis: active, front porch, sync, back porch.
- Divider: div counts 0..CLK_DIV-1 and wraps. p_tick = EN && (div == CLK_DIV-1). With CLK_DIV=1, p_tick = EN.
- Counters:
  - Counters update only on a CLK edge where p_tick = 1.
  - x increments, and wraps H_TOTAL-1 -> 0.
  - y increments only when x wraps, and wraps V_TOTAL-1 -> 0.
- hsync, vsync, video_on, line_start and frame_start are decoded from the next-state counters and registered. They therefore change on the same edge as pixel_x/pixel_y, with zero skew and no decode glitches.
- hsync is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync uses the same rule on y with the V parameters.
- line_start / frame_start are high for exactly one CLK cycle: the cycle after the p_tick edge that loaded x=0 / (0,0). Otherwise they are 0.
- Reset (RESET_N low, any time, asynchronous):
  - div=0, pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1.
  - hsync=~HS_POL, vsync=~VS_POL.
  - video_on=0, line_start=0, frame_start=0, line_irq=0, p_tick=0.
  - The first p_tick after release wraps the raster to (0,0), asserting frame_start and line_start.
- EN low: div is held at 0, p_tick=0, and all counters and levels hold. Strobes deassert after one cycle. On EN rising, the next p_tick occurs CLK_DIV-1 cycles later.
- Reset mid-frame discards position; the raster restarts as described above.

Optional Feature:
- Macro: VGA_LINE_IRQ_EN.
- Defined: line_irq pulses for one CLK cycle, aligned with line_start, when the new pixel_y equals line_cmp. line_cmp is sampled on that same p_tick edge. line_cmp >= V_TOTAL never fires.
- Undefined: line_irq is tied 0, line_cmp is unused, and the comparator logic is absent. The port list is identical in both builds.

Decomposition:
- Package vga_timing_pkg:
  - mode constants for 640x480@60, 800x600@60 and 1024x768@60 (porches, sync widths, polarities);
  - H_TOTAL/V_TOTAL helpers;
  - a clog2-based minimum-width function.
- Sub-module vga_pixel_div (CLK_DIV counter plus p_tick, with EN and RESET_N) is natural and reusable by the pixel generator.

Test Plan:
- Default params, CLK_DIV=2, release reset: first p_tick at cycle 1. Next cycle shows (0,0), frame_start=1, line_start=1, video_on=1.
- Free-run one line: hsync=0 exactly for x=656..751 (96 pixels). video_on falls at x=640. Line period = 1600 CLK.
- Free-run a full frame: vsync low for y=490..491. frame_start period = 800*525*2 = 840000 CLK. No strobe at any other point.
- CLK_DIV=1, HS_POL=1, VS_POL=1, 800x600 mode (H 800/40/128/88, V 600/1/4/23): hsync high for x=840..967. H_TOTAL=1056, V_TOTAL=628.
- Drop EN at (100,20) for 37 cycles: outputs frozen. Re-raise EN: next p_tick after CLK_DIV-1 cycles gives (101,20). Assert RESET_N low at (300,200): outputs go to reset values immediately.
- VGA_LINE_IRQ_EN, line_cmp=479: exactly one line_irq per frame, coincident with line_start at y=479. Repeat with line_cmp=600: no pulse.
